pipeline_skid_stage: RTL

//   Elastic inter-stage pipeline register: successor to the stall/bubble stage register, used between
//   IF/ID/EX/MEM/WB. Replaces stall_current/stall_next with a valid/ready handshake and a 2-entry

---
 rtl/pipeline_skid_stage.sv | 103 ++++++++++
 1 files changed

// File: rtl/pipeline_skid_stage.sv
// Elastic pipeline register with a 2-entry skid buffer, flush and a saturating stall counter.
// Latency 1 cycle; registered in_ready drops only once the skid entry is occupied.
module pipeline_skid_stage #(
   parameter int               WIDTH  = 32,
   parameter logic [WIDTH-1:0] BUBBLE = '0,
   parameter int               CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      cnt_d   = cnt_q;

      case (state_q)
         ST_EMPTY: begin
            if (in_valid) begin
               main_d  = in_data;
               state_d = ST_FULL;
            end
         end
         ST_FULL: begin
            if (out_ready) begin
               if (in_valid) begin
                  main_d = in_data;
               end else begin
                  main_d  = BUBBLE;
                  state_d = ST_EMPTY;
               end
            end else if (in_valid) begin
               skid_d  = in_data;
               state_d = ST_SKID;
            end
         end
         ST_SKID: begin
            // in_ready is low here, so the skid entry is the only thing that can move
            if (out_ready) begin
               main_d  = skid_q;
               skid_d  = BUBBLE;
               state_d = ST_FULL;
            end
         end
         default: begin
            state_d = ST_EMPTY;
            main_d  = BUBBLE;
            skid_d  = BUBBLE;
         end
      endcase

      if (flush) begin
         state_d = ST_EMPTY;
         main_d  = BUBBLE;
         skid_d  = BUBBLE;
      end

      // Counter survives flush; it is debug state, not pipeline state
      if (out_valid && !out_ready && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         main_q  <= BUBBLE;
         skid_q  <= BUBBLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         cnt_q   <= cnt_d;
      end
   end

   assign out_valid = (state_q != ST_EMPTY);
   assign in_ready  = (state_q != ST_SKID);
   assign out_data  = out_valid ? main_q : BUBBLE;
   assign stall_cnt = cnt_q;

endmodule
